// File: rtl/dsp_mac_sequencer.sv
// Streaming MAC controller for a DSP48A1 slice. It feeds A/B/OPMODE so that P
// accumulates one vector's dot product, then tracks P to return the result.
module dsp_mac_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [CNT_W-1:0] res_len,
  output logic             res_carry
);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]          state_reg;
  logic [1:0]          state_next;
  logic [1:0]          rst_sync_reg;
  logic                accept;
  logic                res_fire;

  logic                first_reg;
  logic                acc_d_reg;
  logic                first_d_reg;
  logic                last_d_reg;
  logic                sub_d_reg;
  logic [7:0]          opmode_next;

  logic [17:0]         dsp_a_reg;
  logic [17:0]         dsp_b_reg;
  logic [7:0]          dsp_opmode_reg;

  logic [PIPE_LAT-1:0] pipe_valid_reg;
  logic [PIPE_LAT-1:0] pipe_first_reg;
  logic [PIPE_LAT-1:0] pipe_last_reg;
  logic [PIPE_LAT-1:0] pipe_valid_next;
  logic [PIPE_LAT-1:0] pipe_first_next;
  logic [PIPE_LAT-1:0] pipe_last_next;
  logic                land_valid;
  logic                land_first;
  logic                land_last;

  logic                sticky_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [47:0]         res_data_reg;
  logic [CNT_W-1:0]    res_len_reg;
  logic                res_carry_reg;

  // Slice reset releases on the 2nd edge after rst_n rises; input opens with it.
  assign dsp_rst  = ~rst_sync_reg[1];
  assign in_ready = (state_reg == ACCUM) && !dsp_rst;
  assign accept   = in_valid && in_ready;
  assign res_valid = (state_reg == HOLD);
  assign res_fire = res_valid && res_ready;

  assign dsp_a      = dsp_a_reg;
  assign dsp_b      = dsp_b_reg;
  assign dsp_opmode = dsp_opmode_reg;
  assign res_data   = res_data_reg;
  assign res_len    = res_len_reg;
  assign res_carry  = res_carry_reg;

  // The first product of a vector uses Z=0 so stale P never leaks in.
  always_comb begin
    opmode_next = 8'h08;
    if (acc_d_reg) begin
      opmode_next = {sub_d_reg, 3'b000, ~first_d_reg, 3'b001};
    end
  end

  // The landing pipe is fed from the delayed accept so its tail lines up
  // with the cycle in which P shows the tagged element.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_next[gi] = acc_d_reg;
        assign pipe_first_next[gi] = first_d_reg;
        assign pipe_last_next[gi]  = last_d_reg;
      end else begin : g_tail
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_first_next[gi] = pipe_first_reg[gi-1];
        assign pipe_last_next[gi]  = pipe_last_reg[gi-1];
      end
    end
  endgenerate

  assign land_valid = pipe_valid_reg[PIPE_LAT-1];
  assign land_first = pipe_first_reg[PIPE_LAT-1];
  assign land_last  = pipe_last_reg[PIPE_LAT-1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (land_valid && land_last) state_next = HOLD;
      HOLD:    if (res_fire) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
      state_reg    <= ACCUM;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      state_reg    <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a_reg      <= '0;
      dsp_b_reg      <= '0;
      dsp_opmode_reg <= 8'h00;
      first_reg      <= 1'b1;
      acc_d_reg      <= 1'b0;
      first_d_reg    <= 1'b0;
      last_d_reg     <= 1'b0;
      sub_d_reg      <= 1'b0;
      count_reg      <= '0;
    end else begin
      acc_d_reg      <= accept;
      first_d_reg    <= first_reg;
      last_d_reg     <= in_last;
      sub_d_reg      <= in_sub;
      dsp_opmode_reg <= opmode_next;
      if (accept) begin
        dsp_a_reg <= in_a;
        dsp_b_reg <= in_b;
        first_reg <= 1'b0;
        if (count_reg != CNT_MAX) count_reg <= count_reg + CNT_W'(1);
      end
      if (res_fire) begin
        first_reg <= 1'b1;
        count_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= '0;
      pipe_first_reg <= '0;
      pipe_last_reg  <= '0;
    end else begin
      pipe_valid_reg <= pipe_valid_next;
      pipe_first_reg <= pipe_first_next;
      pipe_last_reg  <= pipe_last_next;
    end
  end

  // A single-element vector must not inherit the previous vector's sticky carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg    <= 1'b0;
      res_data_reg  <= '0;
      res_len_reg   <= '0;
      res_carry_reg <= 1'b0;
    end else if (land_valid) begin
      sticky_reg <= land_first ? dsp_carryout : (sticky_reg | dsp_carryout);
      if (land_last) begin
        res_data_reg  <= dsp_p;
        res_len_reg   <= count_reg;
        res_carry_reg <= (land_first ? 1'b0 : sticky_reg) | dsp_carryout;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer, with a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registered) closing the loop on DSP_P/DSP_CARRYOUT.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        in_sub;
  logic        in_last;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_rst;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic [15:0] res_len;
  logic        res_carry;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  dsp_mac_sequencer #(.PIPE_LAT(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_rst(dsp_rst),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_len(res_len), .res_carry(res_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slice model
  logic signed [17:0] a1_reg;
  logic signed [17:0] b1_reg;
  logic signed [35:0] m_reg;
  logic [7:0]         opm_reg;
  logic [47:0]        p_reg;
  logic               co_reg;
  logic [47:0]        x_sel;
  logic [47:0]        z_sel;
  logic [48:0]        sum49;

  always_comb begin
    x_sel = 48'd0;
    z_sel = 48'd0;
    if (opm_reg[1:0] == 2'b01) x_sel = {{12{m_reg[35]}}, m_reg};
    if (opm_reg[3:2] == 2'b10) z_sel = p_reg;
    sum49 = opm_reg[7] ? ({1'b0, z_sel} - {1'b0, x_sel}) : ({1'b0, z_sel} + {1'b0, x_sel});
  end

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1_reg <= '0; b1_reg <= '0; m_reg <= '0; opm_reg <= '0; p_reg <= '0; co_reg <= 1'b0;
    end else begin
      a1_reg  <= dsp_a;
      b1_reg  <= dsp_b;
      m_reg   <= a1_reg * b1_reg;
      opm_reg <= dsp_opmode;
      p_reg   <= sum49[47:0];
      co_reg  <= sum49[48];
    end
  end

  assign dsp_p        = p_reg;
  assign dsp_carryout = co_reg;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic sub, input logic last);
    int w;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_last = last;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("send_timeout_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [47:0] exp_data, input int exp_len,
                            input logic exp_carry, input logic chk_carry, input int stall);
    int w;
    w = 0;
    while (!res_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
    check_eq({tag, "_latency"}, 64'(cyc - last_acc), 64'd4);
    for (int i = 0; i < stall; i++) begin
      check_eq({tag, "_stall_data"}, {16'd0, res_data}, {16'd0, exp_data});
      check_eq({tag, "_stall_in_ready"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, {63'd0, res_valid}, 64'd1);
    end
    check_eq({tag, "_data"}, {16'd0, res_data}, {16'd0, exp_data});
    check_eq({tag, "_len"}, {48'd0, res_len}, 64'(exp_len));
    if (chk_carry) check_eq({tag, "_carry"}, {63'd0, res_carry}, {63'd0, exp_carry});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
    check_eq({tag, "_in_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_last = 1'b0;
    res_ready = 1'b0;

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    check_eq("rst_dsp_a", {46'd0, dsp_a}, 64'd0);
    check_eq("rst_dsp_b", {46'd0, dsp_b}, 64'd0);
    check_eq("rst_opmode", {56'd0, dsp_opmode}, 64'h00);
    check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check_eq("rst_res_data", {16'd0, res_data}, 64'd0);
    check_eq("rst_res_len", {48'd0, res_len}, 64'd0);
    check_eq("rst_res_carry", {63'd0, res_carry}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel1_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    check_eq("rel1_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check_eq("rel2_dsp_rst", {63'd0, dsp_rst}, 64'd0);
    check_eq("rel2_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back dot product with 5 cycles of result backpressure
    send(18'd2, 18'd10, 1'b0, 1'b0);
    send(18'd3, 18'd10, 1'b0, 1'b0);
    send(18'd4, 18'd10, 1'b0, 1'b1);
    get_result("dot3", 48'd90, 3, 1'b0, 1'b1, 5);

    // Bubbles and subtract
    send(18'd5, 18'd10, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("opm_first_add", {56'd0, dsp_opmode}, 64'h01);
    @(negedge clk);
    check_eq("opm_bubble1", {56'd0, dsp_opmode}, 64'h08);
    send(18'd2, 18'd10, 1'b1, 1'b1);
    check_eq("opm_bubble2", {56'd0, dsp_opmode}, 64'h08);
    @(negedge clk);
    check_eq("opm_later_sub", {56'd0, dsp_opmode}, 64'h89);
    get_result("sub2", 48'd30, 2, 1'b0, 1'b0, 0);

    // Single-element subtract vector: 0 - 7*3
    send(18'd7, 18'd3, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("opm_single_sub", {56'd0, dsp_opmode}, 64'h81);
    get_result("single", 48'hFFFF_FFFF_FFEB, 1, 1'b0, 1'b0, 0);

    // Overflow: 16385 x (0x1FFFF * 0x1FFFF)
    for (int i = 0; i < 16385; i++) send(18'h1FFFF, 18'h1FFFF, 1'b0, i == 16384);
    get_result("ovf", 48'h2_FFFC_4001, 16385, 1'b1, 1'b1, 0);

    // Reset mid-vector
    send(18'd9, 18'd9, 1'b0, 1'b0);
    send(18'd8, 18'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("mid_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    check_eq("mid_dsp_a", {46'd0, dsp_a}, 64'd0);
    check_eq("mid_opmode", {56'd0, dsp_opmode}, 64'h00);
    check_eq("mid_res_data", {16'd0, res_data}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check_eq("mid_no_result", 64'(seen), 64'd0);
    check_eq("mid_res_len", {48'd0, res_len}, 64'd0);
    for (int i = 0; i < 7; i++) send(18'd1, 18'd1, 1'b0, i == 6);
    get_result("after_rst", 48'd7, 7, 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

- Streaming multiply-accumulate controller placed directly upstream of a DSP48A1 slice; it also consumes the slice's output.
- Accepts (A, B) operand pairs over a valid/ready handshake and drives the slice's A, B and OPMODE ports so that P accumulates the dot product of one vector.
- Watches the slice's pipeline and returns the 48-bit sum, element count and sticky overflow over a valid/ready result handshake.
- Slice configuration at top level: A1REG=B1REG=MREG=PREG=OPMODEREG=CARRYOUTREG=1, all CE tied 1, D/C/PCIN/CARRYIN tied 0, CARRYINSEL="OPMODE5".

## Interface
- PIPE_LAT, 3: rising edges from operand acceptance to DSP_P/DSP_CARRYOUT reflecting that element. Covers the sequencer's output register plus A1/M/P.
- CNT_W, 16: width of RES_LEN.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  sequencer accepts a pair this cycle.
- IN_A  in  18  multiplier operand A.
- IN_B  in  18  multiplier operand B.
- IN_SUB  in  1  subtract this product instead of adding it.
- IN_LAST  in  1  final element of the vector.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_RST  out  1  to all slice RST* inputs; active-high.
- DSP_P  in  48  from slice P.
- DSP_CARRYOUT  in  1  from slice CARRYOUT.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed.
- RES_DATA  out  48  accumulated sum.
- RES_LEN  out  CNT_W  number of elements in the vector.
- RES_CARRY  out  1  OR of DSP_CARRYOUT over all elements of the vector.

## Operation
**Accept rule:** a pair is accepted on an edge where IN_VALID && IN_READY.

**FSM states:**
- ACCUM: IN_READY=1 unless DSP_RST=1.
  - Accepting IN_LAST moves to DRAIN.
- DRAIN: IN_READY=0.
  - Waits until the last element lands, then captures the result and moves to HOLD.
- HOLD: RES_VALID=1, IN_READY=0.
  - RES_VALID && RES_READY moves to ACCUM.

**Per accepted element:**
- DSP_A/DSP_B are registered from IN_A/IN_B.
- One edge later, DSP_OPMODE is registered as follows:
  - First element of vector, add: 0x01 (X=M, Z=0).
  - First element of vector, subtract: 0x81.
  - Later element, add: 0x09 (X=M, Z=P).
  - Later element, subtract: 0x89.
- The "first" flag sets on reset and after each result handshake, and clears on acceptance.
- A single-element vector (first and last) uses 0x01/0x81.

**No-accept cycles:**
- Any edge without an accept (bubble, DRAIN, HOLD) registers DSP_OPMODE=0x08 one edge later (X=0, Z=P), so P holds.
- DSP_A/DSP_B keep their last values.

**Landing tracking:**
- A PIPE_LAT-deep shift register carries {valid, first, last} per edge.
- On the edge after an element lands:
  - The sticky carry loads DSP_CARRYOUT if the element was first, otherwise ORs DSP_CARRYOUT in.
  - If the element was last: RES_DATA←DSP_P, RES_CARRY←sticky|DSP_CARRYOUT, RES_LEN←count, RES_VALID←1.

**Counter and arithmetic:**
- The element counter increments on each accept and saturates at 2^CNT_W−1.
- It resets to 0 on the result handshake.
- Arithmetic is done entirely by the slice, modulo 2^48; the sequencer never modifies DSP_P.

## Timing
**Reset values:**
- IN_READY=0, DSP_A=0, DSP_B=0, DSP_OPMODE=0x00.
- RES_VALID=0, RES_DATA=0, RES_LEN=0, RES_CARRY=0.
- Landing pipe cleared, state ACCUM, first=1.

**DSP_RST:**
- Asserts asynchronously with RSTN low.
- Deasserts at the 2nd rising edge after RSTN rises; IN_READY rises at that same point.

**Latency:**
- Element accepted at edge e: DSP_A/B update at e, DSP_OPMODE at e+1, DSP_P at e+PIPE_LAT.
- Last accepted at edge e: RES_VALID high after edge e+PIPE_LAT+1.
- Throughput: one vector per N+PIPE_LAT+2 cycles.

**Handshake rules:**
- RES_DATA/RES_LEN/RES_CARRY are stable while RES_VALID && !RES_READY.
- RES_VALID drops on the edge after the handshake; IN_READY is 1 in the next cycle.
- IN_READY does not depend combinationally on IN_VALID.

**Reset mid-vector:** RSTN low at any time aborts the vector; no result is produced and all outputs return to reset values.

## Test plan
- **Reset:** hold RSTN low 3 cycles, then release → all outputs at reset values; DSP_RST=1 until 2nd edge after release, then IN_READY=1.
- **Back-to-back dot product:** A={2,3,4}, B={10,10,10} on consecutive cycles, IN_LAST on 3rd → RES_DATA=90, RES_LEN=3, RES_CARRY=0; RES_VALID high after edge e+4.
- **Bubbles and subtract:**
  - Pairs (5,10) add, 2-cycle IN_VALID gap, then (2,10) IN_SUB=1, last → RES_DATA=30, RES_LEN=2.
  - DSP_OPMODE sequence 0x01, 0x08, 0x08, 0x89.
- **Overflow:** 16385 pairs of A=B=0x1FFFF, back-to-back → RES_DATA=0x2FFFC4001, RES_CARRY=1, RES_LEN=16385.
- **Result backpressure:** RES_READY low 5 cycles after RES_VALID → result outputs stable, IN_READY=0; raise RES_READY → RES_VALID=0 and IN_READY=1 next cycle.
- **Reset mid-vector:**
  - After 2 elements accepted, pulse RSTN low 1 cycle → no RES_VALID, outputs at reset values.
  - Then vector A=B={1,…} with 7 elements → RES_DATA=7, RES_LEN=7.
